// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder bit per clock, WIDTH cycles per add.
// Optional SERIAL_ADDER_CIN_EN adds a carry_in port that seeds the carry flop.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_CIN_EN
    input  logic             carry_in,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
    logic [CW-1:0]    cnt;
    logic             c, s, c_nxt, cin_seed;

`ifdef SERIAL_ADDER_CIN_EN
    assign cin_seed = carry_in;
`else
    assign cin_seed = 1'b0;
`endif

    assign s       = a_sh[0] ^ b_sh[0] ^ c;
    assign c_nxt   = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    assign res_nxt = (res_sh >> 1) | {s, {(WIDTH-1){1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // cnt stops at LAST on the final edge so it never wraps for power-of-two WIDTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            cnt       <= '0;
            c         <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        c    <= cin_seed;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_nxt;
                    c      <= c_nxt;
                    if (cnt == LAST) begin
                        sum       <= res_nxt;
                        carry_out <= c_nxt;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
